// File: rtl/nonce_tx_queue_pkg.sv
// Shared widths, TX state encoding and watchdog length for the nonce TX queue.
package nonce_tx_queue_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WD_LEN = 4;
  localparam int unsigned WD_W   = 2;

  typedef enum logic [3:0] {
    TX_IDLE      = 4'b0001,
    TX_SEND      = 4'b0010,
    TX_WAIT_BUSY = 4'b0100,
    TX_WAIT_DONE = 4'b1000
  } tx_state_e;

endpackage

// File: rtl/nonce_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop together are allowed when full.
module nonce_sync_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; count disambiguates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nonce_tx_queue.sv
// Captures per-slave nonce strobes, arbitrates them round-robin into a FIFO
// and drains the FIFO into serial_transmit over its send/busy handshake.
module nonce_tx_queue
  import nonce_tx_queue_pkg::*;
#(
  parameter int unsigned SLAVES     = 2,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SLAVES*WORD_W-1:0] slave_nonces,
  input  logic [SLAVES-1:0]        new_nonces,
  input  logic                     serial_busy,
  output logic                     serial_send,
  output logic [WORD_W-1:0]        golden_nonce,
  output logic [DEPTH_LOG2:0]      fifo_count,
  output logic                     overflow
);

  localparam int unsigned IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  logic [WORD_W-1:0] pend_word [SLAVES];
  logic [SLAVES-1:0] pend_valid;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic              ovf_c;

  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_head;

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic              pop_c;
  logic              send_nxt;

  // Round-robin pick: first valid slave at or after rr_ptr; lowest offset wins.
  always_comb begin
    logic [IDX_W-1:0] sel;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = SLAVES - 1; k >= 0; k--) begin
      sel = IDX_W'((int'(rr_ptr) + k) % SLAVES);
      if (pend_valid[sel] && !fifo_full) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end
  end

  always_comb begin
    ovf_c = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      if (new_nonces[i] && pend_valid[i] && !(grant_any && (grant_idx == IDX_W'(i))))
        ovf_c = 1'b1;
    end
  end

  // A strobe in the grant cycle re-latches the newer word and keeps it valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= '0;
      rr_ptr     <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < SLAVES; i++) pend_word[i] <= '0;
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (new_nonces[i]) begin
          pend_word[i]  <= slave_nonces[i*WORD_W +: WORD_W];
          pend_valid[i] <= 1'b1;
        end else if (grant_any && (grant_idx == IDX_W'(i))) begin
          pend_valid[i] <= 1'b0;
        end
      end
      if (grant_any) rr_ptr <= IDX_W'((int'(grant_idx) + 1) % SLAVES);
      if (ovf_c)     overflow <= 1'b1;
    end
  end

  nonce_sync_fifo #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_any),
    .push_data (pend_word[grant_idx]),
    .pop       (pop_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:      if (!fifo_empty && !serial_busy) state_nxt = TX_SEND;
      TX_SEND:      state_nxt = TX_WAIT_BUSY;
      TX_WAIT_BUSY: begin
        if (serial_busy)                            state_nxt = TX_WAIT_DONE;
        else if (wd_cnt == WD_W'(WD_LEN - 1))       state_nxt = TX_IDLE;
      end
      TX_WAIT_DONE: if (!serial_busy) state_nxt = TX_IDLE;
      default:      state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    pop_c    = 1'b0;
    send_nxt = 1'b0;
    if (state == TX_IDLE && !fifo_empty && !serial_busy) begin
      pop_c    = 1'b1;
      send_nxt = 1'b1;
    end
  end

  // Watchdog: a word whose send never raises busy is still counted as sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       wd_cnt <= '0;
    else if (state == TX_WAIT_BUSY && !serial_busy) wd_cnt <= wd_cnt + 1'b1;
    else                                           wd_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serial_send  <= 1'b0;
      golden_nonce <= '0;
    end else begin
      serial_send <= send_nxt;
      if (pop_c) golden_nonce <= fifo_head;
    end
  end

endmodule

// File: tb/tb_nonce_tx_queue.sv
// Directed self-checking bench for nonce_tx_queue with a simple serial_transmit busy model.
module tb_nonce_tx_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] slave_nonces = '0;
  logic [1:0]  new_nonces = '0;
  logic        serial_busy;
  logic        serial_send;
  logic [31:0] golden_nonce;
  logic [3:0]  fifo_count;
  logic        overflow;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  logic        force_busy = 1'b0;
  logic        no_busy    = 1'b0;
  int unsigned busy_cnt;

  logic [31:0] sent_q [$];
  int unsigned send_cyc [$];
  logic [31:0] exp_q [$];

  nonce_tx_queue dut (
    .clk          (clk),
    .rst          (rst),
    .slave_nonces (slave_nonces),
    .new_nonces   (new_nonces),
    .serial_busy  (serial_busy),
    .serial_send  (serial_send),
    .golden_nonce (golden_nonce),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // serial_transmit model: busy for 10 cycles after each send request
  always @(posedge clk or posedge rst) begin
    if (rst)                          busy_cnt <= 0;
    else if (serial_send && !no_busy) busy_cnt <= 10;
    else if (busy_cnt != 0)           busy_cnt <= busy_cnt - 1;
  end
  assign serial_busy = force_busy | (busy_cnt != 0);

  always @(negedge clk) begin
    if (serial_send) begin
      sent_q.push_back(golden_nonce);
      send_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    new_nonces = '0;
    force_busy = 1'b0;
    no_busy = 1'b0;
    #3;
    sent_q.delete();
    send_cyc.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Drive one strobe cycle; caller sits just after a rising edge.
  task automatic strobe(input logic [1:0] m, input logic [31:0] w0, input logic [31:0] w1);
    slave_nonces = {w1, w0};
    new_nonces = m;
    tick(1);
    new_nonces = '0;
  endtask

  task automatic drain(input string tag, input int n);
    int budget = 600;
    while (sent_q.size() < n && budget > 0) begin
      tick(1);
      budget--;
    end
    tick(15);
    chk(tag, 32'(sent_q.size()), 32'(n));
  endtask

  task automatic chk_seq(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < sent_q.size()) ? sent_q[i] : 32'hxxxx_xxxx, exp_q[i]);
  endtask

  initial begin
    do_reset();
    chk("rst_send", 32'(serial_send), 0);
    chk("rst_golden", golden_nonce, 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // 1: single strobe latency
    strobe(2'b01, 32'hDEADBEEF, 32'h0);
    chk("t1_send_t", 32'(serial_send), 0);
    tick(1);
    chk("t1_send_t1", 32'(serial_send), 0);
    chk("t1_count_t1", 32'(fifo_count), 1);
    tick(1);
    chk("t1_send_t2", 32'(serial_send), 1);
    chk("t1_golden", golden_nonce, 32'hDEADBEEF);
    tick(1);
    chk("t1_send_drop", 32'(serial_send), 0);
    tick(20);
    chk("t1_once", 32'(sent_q.size()), 1);
    chk("t1_hold", golden_nonce, 32'hDEADBEEF);

    // 2: round-robin from rr_ptr=0, then from rr_ptr=1
    do_reset();
    strobe(2'b11, 32'hA0000001, 32'hB0000002);
    drain("t2_n1", 2);
    strobe(2'b01, 32'hC0000003, 32'h0);
    drain("t2_n2", 3);
    strobe(2'b11, 32'hA0000011, 32'hB0000012);
    drain("t2_n3", 5);
    exp_q = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hB0000012, 32'hA0000011};
    chk_seq("t2_word");

    // 3: full FIFO, pending word, overflow
    do_reset();
    force_busy = 1'b1;
    for (int i = 1; i <= 9; i++) strobe(2'b01, 32'h30000000 + 32'(i), 32'h0);
    tick(1);
    chk("t3_count", 32'(fifo_count), 8);
    chk("t3_ovf_pre", 32'(overflow), 0);
    strobe(2'b01, 32'h3000000A, 32'h0);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_count_full", 32'(fifo_count), 8);
    force_busy = 1'b0;
    drain("t3_n", 9);
    exp_q = '{32'h30000001, 32'h30000002, 32'h30000003, 32'h30000004, 32'h30000005,
              32'h30000006, 32'h30000007, 32'h30000008, 32'h3000000A};
    chk_seq("t3_word");

    // 4: strobe in the cycle the slave is granted
    do_reset();
    strobe(2'b10, 32'h0, 32'h40000001);
    strobe(2'b10, 32'h0, 32'h40000002);
    drain("t4_n", 2);
    chk("t4_ovf", 32'(overflow), 0);
    exp_q = '{32'h40000001, 32'h40000002};
    chk_seq("t4_word");

    // 5: busy never rises, watchdog returns to IDLE
    do_reset();
    no_busy = 1'b1;
    strobe(2'b11, 32'h50000001, 32'h50000002);
    drain("t5_n", 2);
    chk("t5_gap", (send_cyc.size() == 2) ? 32'(send_cyc[1] - send_cyc[0]) : 32'hFFFF_FFFF, 6);
    exp_q = '{32'h50000001, 32'h50000002};
    chk_seq("t5_word");

    // 6: reset during WAIT_DONE with 3 words queued
    do_reset();
    for (int i = 1; i <= 4; i++) strobe(2'b01, 32'h60000000 + 32'(i), 32'h0);
    tick(3);
    chk("t6_count_pre", 32'(fifo_count), 3);
    chk("t6_busy_pre", 32'(serial_busy), 1);
    rst = 1'b1;
    #1;
    chk("t6_count_rst", 32'(fifo_count), 0);
    chk("t6_send_rst", 32'(serial_send), 0);
    chk("t6_golden_rst", golden_nonce, 0);
    sent_q.delete();
    tick(2);
    rst = 1'b0;
    tick(30);
    chk("t6_no_send", 32'(sent_q.size()), 0);
    strobe(2'b01, 32'h6000000F, 32'h0);
    drain("t6_after_n", 1);
    chk("t6_after_word", (sent_q.size() > 0) ? sent_q[0] : 32'h0, 32'h6000000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
